instr_fetch_unit: RTL

- Sits between the single-cycle control/execute block and instruction memory.
- Takes the current PC (`fetch_addr`) and runs a request/grant/response handshake with instruction memory (one request outstanding at most).
- Holds the fetched word and presents `instruction_read` / `instruction_ready` to the control block.
- Handles PC changes mid-fetch, misaligned PCs and memory timeouts.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_watchdog.sv | 32 +++
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    FAULT,
    ERR
  } fetch_state_t;

  localparam logic [31:0] NOP_INSN        = 32'h00000013;
  localparam int unsigned IMEM_WORD_BYTES = 4;
  localparam int unsigned ALIGN_BITS      = $clog2(IMEM_WORD_BYTES);

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[ALIGN_BITS-1:0] == '0;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Response watchdog: a down-counter reloaded on clear, flags expiry once the
// enabled count has run TIMEOUT_CYCLES cycles without a clear.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LOAD_VAL = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = LOAD_VAL;
    else if (enable && (cnt_q != '0))
      cnt_d = cnt_q - 16'd1;
  end

  assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding request/grant/response fetcher that
// holds the last word for the control block and tracks PC moves mid-fetch.
//
// state | meaning
// IDLE  | out of reset, latch first PC
// REQ   | imem_req high, waiting for grant
// WAIT  | granted, waiting for rvalid (watchdog running)
// VALID | instruction held for held_addr
// FAULT | PC misaligned, no access made
// ERR   | memory timed out, wait for PC to move
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSN_VAL   = NOP_INSN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  output logic [31:0] instruction_read,
  output logic        instruction_ready,
  output logic        fetch_misaligned,
  output logic        bus_error,
  output logic [31:0] fetch_count,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  fetch_state_t state_q, state_d;
  logic [31:0]  held_addr_q, held_addr_d;
  logic [31:0]  insn_q, insn_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         outstanding_q, outstanding_d;
  logic         stale_q, stale_d;
  logic         addr_moved, addr_ok, wd_expired;

  assign addr_moved = fetch_addr != held_addr_q;
  assign addr_ok    = is_aligned(fetch_addr);

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == REQ) && imem_gnt),
    .enable (state_q == WAIT),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      held_addr_q   <= '0;
      insn_q        <= NOP_INSN_VAL;
      fetch_count_q <= '0;
      outstanding_q <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_addr_q   <= held_addr_d;
      insn_q        <= insn_d;
      fetch_count_q <= fetch_count_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    held_addr_d   = held_addr_q;
    insn_d        = insn_q;
    fetch_count_d = fetch_count_q;
    outstanding_d = outstanding_q;
    stale_d       = stale_q;
    case (state_q)
      IDLE, FAULT: begin
        if (addr_ok) begin
          state_d     = REQ;
          held_addr_d = fetch_addr;
        end else begin
          state_d = FAULT;
        end
      end
      REQ: begin
        if (imem_gnt && imem_rvalid && !addr_moved) begin
          insn_d        = imem_rdata;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = VALID;
        end else if (imem_gnt && !imem_rvalid) begin
          outstanding_d = 1'b1;
          state_d       = WAIT;
        end else if (addr_moved) begin
          // Before grant the address may follow the PC; a same-cycle response
          // for the old address is simply dropped.
          if (addr_ok) held_addr_d = fetch_addr;
          else         state_d     = FAULT;
        end
      end
      WAIT: begin
        if (imem_rvalid && outstanding_q) begin
          outstanding_d = 1'b0;
          stale_d       = 1'b0;
          if (stale_q || addr_moved) begin
            if (addr_ok) begin
              state_d     = REQ;
              held_addr_d = fetch_addr;
            end else begin
              state_d = FAULT;
            end
          end else begin
            insn_d        = imem_rdata;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = VALID;
          end
        end else begin
          if (addr_moved) stale_d = 1'b1;
          if (wd_expired) begin
            state_d       = ERR;
            outstanding_d = 1'b0;
            stale_d       = 1'b0;
          end
        end
      end
      VALID, ERR: begin
        if (addr_moved) begin
          if (addr_ok) begin
            state_d     = REQ;
            held_addr_d = fetch_addr;
          end else begin
            state_d = FAULT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req          = state_q == REQ;
    imem_addr         = held_addr_q;
    instruction_ready = (state_q == VALID) && !addr_moved;
    instruction_read  = (state_q == VALID) ? insn_q : NOP_INSN_VAL;
    fetch_misaligned  = state_q == FAULT;
    bus_error         = state_q == ERR;
    fetch_count       = fetch_count_q;
  end

endmodule
